// File: rtl/ysyx_22040386_pkg.sv
// Shared encodings for the MEM stage: load/store mask, branch type and the
// data-memory handshake FSM states.
package ysyx_22040386_pkg;

    localparam logic [2:0] MASK_LB  = 3'b000;
    localparam logic [2:0] MASK_LH  = 3'b001;
    localparam logic [2:0] MASK_LW  = 3'b010;
    localparam logic [2:0] MASK_LD  = 3'b011;
    localparam logic [2:0] MASK_LBU = 3'b100;
    localparam logic [2:0] MASK_LHU = 3'b101;
    localparam logic [2:0] MASK_LWU = 3'b110;

    // Access size lives in mask[1:0] for both loads and stores
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [2:0] BR_EQ   = 3'b000;
    localparam logic [2:0] BR_NE   = 3'b001;
    localparam logic [2:0] BR_NONE = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/ysyx_22040386_lsu_align.sv
// Combinational byte-lane alignment: store strobes/data shifted into the
// addressed lanes, load data shifted down, truncated and extended.
module ysyx_22040386_lsu_align
    import ysyx_22040386_pkg::*;
(
    input  logic [2:0]  mask,
    input  logic [2:0]  offset,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_sh,
    output logic [63:0] load_data
);
    logic [5:0]  bit_sh;
    logic [7:0]  strb_base;
    logic [63:0] rdata_sh;
    logic        uns;

    assign bit_sh   = {offset, 3'b000};
    assign rdata_sh = rdata >> bit_sh;
    assign wdata_sh = wdata << bit_sh;
    // Lanes pushed past byte 7 by a misaligned access simply fall off
    assign wstrb    = strb_base << offset;
    assign uns      = mask[2];

    always_comb begin
        strb_base = 8'hFF;
        load_data = rdata_sh;
        case (mask[1:0])
            SZ_B: begin
                strb_base = 8'h01;
                load_data = {{56{~uns & rdata_sh[7]}}, rdata_sh[7:0]};
            end
            SZ_H: begin
                strb_base = 8'h03;
                load_data = {{48{~uns & rdata_sh[15]}}, rdata_sh[15:0]};
            end
            SZ_W: begin
                strb_base = 8'h0F;
                load_data = {{32{~uns & rdata_sh[31]}}, rdata_sh[31:0]};
            end
            default: begin
                strb_base = 8'hFF;
                load_data = rdata_sh;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22040386_mem_stage.sv
// MEM stage: valid/ready data-memory transaction with upstream stall,
// branch/jump resolution, and the MEM/WB pipeline register.
module ysyx_22040386_mem_stage
    import ysyx_22040386_pkg::*;
(
    input  logic        i_MEM_clk,
    input  logic        i_MEM_rst,
    input  logic        i_MEM_RegWrite,
    input  logic        i_MEM_MemRead,
    input  logic        i_MEM_MemWrite,
    input  logic        i_MEM_Jal,
    input  logic        i_MEM_Jalr,
    input  logic        i_MEM_zero,
    input  logic [2:0]  i_MEM_Branch_type,
    input  logic [2:0]  i_MEM_mem_mask,
    input  logic [4:0]  i_MEM_reg_wr_addr,
    input  logic [63:0] i_MEM_ALUresult,
    input  logic [63:0] i_MEM_pc_add_imm,
    input  logic [63:0] i_MEM_reg_wr_data,
    input  logic [63:0] i_MEM_mem_wr_data,
    input  logic [63:0] i_MEM_pc,
    input  logic [31:0] i_MEM_inst,
    output logic        o_MEM_dreq_valid,
    input  logic        i_MEM_dreq_ready,
    output logic        o_MEM_dreq_wen,
    output logic [63:0] o_MEM_dreq_addr,
    output logic [63:0] o_MEM_dreq_wdata,
    output logic [7:0]  o_MEM_dreq_wstrb,
    input  logic        i_MEM_drsp_valid,
    input  logic [63:0] i_MEM_drsp_rdata,
    output logic        o_MEM_stall,
    output logic        o_MEM_jump_flag,
    output logic [63:0] o_MEM_jump_target,
    output logic        o_MEM_WB_RegWrite,
    output logic [4:0]  o_MEM_WB_reg_wr_addr,
    output logic [63:0] o_MEM_WB_reg_wr_data,
    output logic [63:0] o_MEM_WB_pc,
    output logic [31:0] o_MEM_WB_inst
);
    mem_state_e  state, state_nxt;
    logic        rst_q;
    logic        memop, fire, rsp_done, br_take;
    logic [63:0] load_data;

    assign memop    = i_MEM_MemRead | i_MEM_MemWrite;
    assign fire     = o_MEM_dreq_valid & i_MEM_dreq_ready;
    assign rsp_done = (state == ST_WAIT) & i_MEM_drsp_valid;

    // Request is suppressed during reset and for one cycle after it
    assign o_MEM_dreq_valid = (((state == ST_IDLE) & memop) | (state == ST_REQ))
                              & ~i_MEM_rst & ~rst_q;
    assign o_MEM_dreq_wen   = i_MEM_MemWrite;
    assign o_MEM_dreq_addr  = {i_MEM_ALUresult[63:3], 3'b000};
    assign o_MEM_stall      = memop & ~rsp_done;

    ysyx_22040386_lsu_align u_align (
        .mask      (i_MEM_mem_mask),
        .offset    (i_MEM_ALUresult[2:0]),
        .wdata     (i_MEM_mem_wr_data),
        .rdata     (i_MEM_drsp_rdata),
        .wstrb     (o_MEM_dreq_wstrb),
        .wdata_sh  (o_MEM_dreq_wdata),
        .load_data (load_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (memop) state_nxt = fire ? ST_WAIT : ST_REQ;
            ST_REQ:  if (fire) state_nxt = ST_WAIT;
            ST_WAIT: if (i_MEM_drsp_valid) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        br_take = 1'b0;
        case (i_MEM_Branch_type)
            BR_EQ:   br_take = i_MEM_zero;
            BR_NE:   br_take = ~i_MEM_zero;
            BR_NONE: br_take = 1'b0;
            default: br_take = 1'b0;
        endcase
    end

    assign o_MEM_jump_flag   = ~o_MEM_stall & (i_MEM_Jal | i_MEM_Jalr | br_take);
    assign o_MEM_jump_target = o_MEM_stall ? 64'd0 :
                               i_MEM_Jalr  ? (i_MEM_ALUresult & ~64'h1) : i_MEM_pc_add_imm;

    always_ff @(posedge i_MEM_clk) begin
        if (i_MEM_rst) begin
            state                <= ST_IDLE;
            rst_q                <= 1'b1;
            o_MEM_WB_RegWrite    <= 1'b0;
            o_MEM_WB_reg_wr_addr <= 5'd0;
            o_MEM_WB_reg_wr_data <= 64'd0;
            o_MEM_WB_pc          <= 64'd0;
            o_MEM_WB_inst        <= 32'd0;
        end else begin
            state <= state_nxt;
            rst_q <= 1'b0;
            if (o_MEM_stall) begin
                // Bubble; data is left untouched
                o_MEM_WB_RegWrite    <= 1'b0;
                o_MEM_WB_reg_wr_addr <= 5'd0;
                o_MEM_WB_pc          <= 64'd0;
                o_MEM_WB_inst        <= 32'd0;
            end else begin
                o_MEM_WB_RegWrite    <= i_MEM_RegWrite;
                o_MEM_WB_reg_wr_addr <= i_MEM_reg_wr_addr;
                o_MEM_WB_reg_wr_data <= i_MEM_MemRead ? load_data : i_MEM_reg_wr_data;
                o_MEM_WB_pc          <= i_MEM_pc;
                o_MEM_WB_inst        <= i_MEM_inst;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_mem_stage.sv
// Self-checking bench for the MEM stage: vector table, hand sequences for
// reset/branch corners, and randomized traffic against a byte-level model.
module tb_ysyx_22040386_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite, MemRead, MemWrite, Jal, Jalr, zero;
    logic [2:0]  Branch_type, mem_mask;
    logic [4:0]  reg_wr_addr;
    logic [63:0] ALUresult, pc_add_imm, reg_wr_data, mem_wr_data, pc;
    logic [31:0] inst;
    logic        dreq_valid, dreq_ready, dreq_wen;
    logic [63:0] dreq_addr, dreq_wdata;
    logic [7:0]  dreq_wstrb;
    logic        drsp_valid;
    logic [63:0] drsp_rdata;
    logic        stall, jump_flag;
    logic [63:0] jump_target;
    logic        wb_RegWrite;
    logic [4:0]  wb_reg_wr_addr;
    logic [63:0] wb_reg_wr_data, wb_pc;
    logic [31:0] wb_inst;

    int checks = 0;
    int errors = 0;
    logic [63:0] pc_cnt = 64'h8000_0000;

    always #5 clk = ~clk;

    ysyx_22040386_mem_stage dut (
        .i_MEM_clk(clk), .i_MEM_rst(rst),
        .i_MEM_RegWrite(RegWrite), .i_MEM_MemRead(MemRead), .i_MEM_MemWrite(MemWrite),
        .i_MEM_Jal(Jal), .i_MEM_Jalr(Jalr), .i_MEM_zero(zero),
        .i_MEM_Branch_type(Branch_type), .i_MEM_mem_mask(mem_mask),
        .i_MEM_reg_wr_addr(reg_wr_addr), .i_MEM_ALUresult(ALUresult),
        .i_MEM_pc_add_imm(pc_add_imm), .i_MEM_reg_wr_data(reg_wr_data),
        .i_MEM_mem_wr_data(mem_wr_data), .i_MEM_pc(pc), .i_MEM_inst(inst),
        .o_MEM_dreq_valid(dreq_valid), .i_MEM_dreq_ready(dreq_ready),
        .o_MEM_dreq_wen(dreq_wen), .o_MEM_dreq_addr(dreq_addr),
        .o_MEM_dreq_wdata(dreq_wdata), .o_MEM_dreq_wstrb(dreq_wstrb),
        .i_MEM_drsp_valid(drsp_valid), .i_MEM_drsp_rdata(drsp_rdata),
        .o_MEM_stall(stall), .o_MEM_jump_flag(jump_flag), .o_MEM_jump_target(jump_target),
        .o_MEM_WB_RegWrite(wb_RegWrite), .o_MEM_WB_reg_wr_addr(wb_reg_wr_addr),
        .o_MEM_WB_reg_wr_data(wb_reg_wr_data), .o_MEM_WB_pc(wb_pc), .o_MEM_WB_inst(wb_inst)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-granular view of the memory rules
    function automatic int size_bytes(input logic [2:0] mask);
        return 1 << mask[1:0];
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] mask, input logic [2:0] off,
                                             input logic [63:0] rd);
        int n = size_bytes(mask);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 8) v[8*i +: 8] = rd[8*(int'(off)+i) +: 8];
        if (!mask[2] && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [2:0] mask, input logic [2:0] off);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < 8; i++)
            if (i >= int'(off) && i < int'(off) + size_bytes(mask)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [2:0] off, input logic [63:0] wd);
        logic [63:0] v = 64'd0;
        for (int i = 0; i + int'(off) < 8; i++) v[8*(i+int'(off)) +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    task automatic set_nop();
        RegWrite = 0; MemRead = 0; MemWrite = 0; Jal = 0; Jalr = 0; zero = 0;
        Branch_type = 3'b010; mem_mask = 3'b000; reg_wr_addr = 5'd0;
        ALUresult = 0; pc_add_imm = 0; reg_wr_data = 0; mem_wr_data = 0; pc = 0; inst = 0;
        dreq_ready = 0; drsp_valid = 0; drsp_rdata = 0;
    endtask

    // Called #1 after a posedge: the instruction enters MEM in this cycle
    task automatic mem_op(input string nm, input logic ld, input logic [2:0] mask,
                          input logic [63:0] alu, input logic [63:0] wd, input logic [63:0] rd,
                          input int rdy_wait, input int rsp_wait, input logic [63:0] exp_data,
                          input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
        logic [63:0] exp_wb;
        logic [4:0]  ea;
        logic [63:0] epc;
        logic [31:0] ei;
        set_nop();
        MemRead = ld; MemWrite = !ld; RegWrite = ld; mem_mask = mask; ALUresult = alu;
        mem_wr_data = wd; reg_wr_addr = 5'($urandom_range(1, 31)); reg_wr_data = {$urandom, $urandom};
        pc = pc_cnt; inst = $urandom; pc_cnt += 4;
        ea = reg_wr_addr; epc = pc; ei = inst;
        exp_wb = ld ? exp_data : reg_wr_data;
        for (int c = 0; c < rdy_wait; c++) begin
            @(negedge clk);
            chk({nm, ".valid_hold"}, dreq_valid, 1);
            chk({nm, ".stall_req"}, stall, 1);
            chk({nm, ".addr_hold"}, dreq_addr, {alu[63:3], 3'b000});
            @(posedge clk); #1;
        end
        dreq_ready = 1;
        @(negedge clk);
        chk({nm, ".valid"}, dreq_valid, 1);
        chk({nm, ".stall_fire"}, stall, 1);
        chk({nm, ".addr"}, dreq_addr, {alu[63:3], 3'b000});
        chk({nm, ".wen"}, dreq_wen, !ld);
        chk({nm, ".jump_in_stall"}, jump_flag, 0);
        if (!ld) begin
            chk({nm, ".wstrb"}, dreq_wstrb, exp_strb);
            chk({nm, ".wdata"}, dreq_wdata, exp_wdata);
        end
        @(posedge clk); #1;
        dreq_ready = 0;
        for (int c = 0; c < rsp_wait; c++) begin
            @(negedge clk);
            chk({nm, ".valid_wait"}, dreq_valid, 0);
            chk({nm, ".stall_wait"}, stall, 1);
            @(posedge clk); #1;
        end
        drsp_valid = 1; drsp_rdata = rd;
        @(negedge clk);
        chk({nm, ".stall_rsp"}, stall, 0);
        chk({nm, ".valid_rsp"}, dreq_valid, 0);
        chk({nm, ".bubble_rw"}, wb_RegWrite, 0);
        chk({nm, ".bubble_pc"}, wb_pc, 0);
        @(posedge clk); #1;
        chk({nm, ".wb_rw"}, wb_RegWrite, ld);
        chk({nm, ".wb_addr"}, wb_reg_wr_addr, ea);
        chk({nm, ".wb_data"}, wb_reg_wr_data, exp_wb);
        chk({nm, ".wb_pc"}, wb_pc, epc);
        chk({nm, ".wb_inst"}, wb_inst, ei);
        set_nop();
    endtask

    // Non-memory instruction, one cycle, with branch/jump fields
    task automatic nop_op(input string nm, input logic jl, input logic jr, input logic z,
                          input logic [2:0] bt, input logic [63:0] alu, input logic [63:0] pai);
        logic ejump;
        logic [63:0] etgt, ed, epc;
        logic [4:0] ea;
        logic [31:0] ei;
        set_nop();
        Jal = jl; Jalr = jr; zero = z; Branch_type = bt; ALUresult = alu; pc_add_imm = pai;
        RegWrite = 1; reg_wr_addr = 5'($urandom_range(0, 31)); reg_wr_data = {$urandom, $urandom};
        pc = pc_cnt; inst = $urandom; pc_cnt += 4;
        ea = reg_wr_addr; ed = reg_wr_data; epc = pc; ei = inst;
        ejump = jl || jr || (bt == 3'b000 && z) || (bt == 3'b001 && !z);
        etgt  = jr ? {alu[63:1], 1'b0} : pai;
        @(negedge clk);
        chk({nm, ".stall"}, stall, 0);
        chk({nm, ".valid"}, dreq_valid, 0);
        chk({nm, ".jump"}, jump_flag, ejump);
        chk({nm, ".target"}, jump_target, etgt);
        @(posedge clk); #1;
        chk({nm, ".wb_rw"}, wb_RegWrite, 1);
        chk({nm, ".wb_addr"}, wb_reg_wr_addr, ea);
        chk({nm, ".wb_data"}, wb_reg_wr_data, ed);
        chk({nm, ".wb_pc"}, wb_pc, epc);
        chk({nm, ".wb_inst"}, wb_inst, ei);
        set_nop();
    endtask

    typedef struct {
        string       nm;
        logic        ld;
        logic [2:0]  mask;
        logic [63:0] alu, wd, rd;
        int          rdy_wait, rsp_wait;
        logic [63:0] exp_data;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{"ld",      1, 3'b011, 64'h8000_0010, 0, 64'h1122334455667788, 0, 0, 64'h1122334455667788, 0, 0};
        tbl[1]  = '{"lb",      1, 3'b000, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0};
        tbl[2]  = '{"lbu",     1, 3'b100, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 0, 1, 64'h80, 0, 0};
        tbl[3]  = '{"lh",      1, 3'b001, 64'h8000_0006, 0, 64'hBEEF_0000_0000_0000, 2, 0, 64'hFFFF_FFFF_FFFF_BEEF, 0, 0};
        tbl[4]  = '{"lwu",     1, 3'b110, 64'h8000_0004, 0, 64'h8765_4321_0000_0000, 0, 2, 64'h8765_4321, 0, 0};
        tbl[5]  = '{"lw",      1, 3'b010, 64'h8000_0004, 0, 64'h8765_4321_0000_0000, 1, 1, 64'hFFFF_FFFF_8765_4321, 0, 0};
        tbl[6]  = '{"sh",      0, 3'b001, 64'h8000_0006, 64'hABCD, 0, 3, 0, 0, 8'hC0, 64'hABCD_0000_0000_0000};
        tbl[7]  = '{"sb",      0, 3'b000, 64'h8000_0005, 64'h12, 0, 0, 0, 0, 8'h20, 64'h0000_1200_0000_0000};
        tbl[8]  = '{"sw",      0, 3'b010, 64'h8000_0004, 64'hDEAD_BEEF, 0, 0, 1, 0, 8'hF0, 64'hDEAD_BEEF_0000_0000};
        tbl[9]  = '{"sd",      0, 3'b011, 64'h8000_0008, 64'h0102_0304_0506_0708, 0, 1, 0, 0, 8'hFF, 64'h0102_0304_0506_0708};
        tbl[10] = '{"sw_mis",  0, 3'b010, 64'h8000_0006, 64'h1122_3344, 0, 0, 0, 0, 8'hC0, 64'h3344_0000_0000_0000};

        // Reset with a load already present: no request, MEM/WB cleared
        set_nop();
        rst = 1;
        MemRead = 1; RegWrite = 1; mem_mask = 3'b011; ALUresult = 64'h8000_0040;
        pc = 64'h8000_1234; inst = 32'h1234_5678; reg_wr_addr = 5'd7; reg_wr_data = 64'h55;
        @(negedge clk);
        chk("rst.valid", dreq_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst.wb_rw", wb_RegWrite, 0);
        chk("rst.wb_addr", wb_reg_wr_addr, 0);
        chk("rst.wb_data", wb_reg_wr_data, 0);
        chk("rst.wb_pc", wb_pc, 0);
        chk("rst.wb_inst", wb_inst, 0);
        rst = 0;
        @(negedge clk);
        chk("post_rst.valid", dreq_valid, 0);
        chk("post_rst.stall", stall, 1);
        @(posedge clk); #1;
        mem_op("post_rst_ld", 1, 3'b011, 64'h8000_0040, 0, 64'hCAFE_F00D_1234_5678, 0, 0,
               64'hCAFE_F00D_1234_5678, 0, 0);

        foreach (tbl[i])
            mem_op(tbl[i].nm, tbl[i].ld, tbl[i].mask, tbl[i].alu, tbl[i].wd, tbl[i].rd,
                   tbl[i].rdy_wait, tbl[i].rsp_wait, tbl[i].exp_data, tbl[i].exp_strb, tbl[i].exp_wdata);

        nop_op("bne",     0, 0, 0, 3'b001, 64'h0, 64'h8000_0100);
        nop_op("jalr",    0, 1, 0, 3'b010, 64'h8000_0203, 64'h8000_0500);
        nop_op("jal",     1, 0, 1, 3'b010, 64'h0, 64'h8000_0600);
        nop_op("beq_nt",  0, 0, 0, 3'b000, 64'h0, 64'h8000_0700);
        nop_op("beq_t",   0, 0, 1, 3'b000, 64'h0, 64'h8000_0704);
        nop_op("bnone",   0, 0, 1, 3'b010, 64'h0, 64'h8000_0800);
        nop_op("bt_rsvd", 0, 0, 1, 3'b111, 64'h0, 64'h8000_0900);

        // Reset while waiting for a response, then a stale response in IDLE
        set_nop();
        MemRead = 1; RegWrite = 1; mem_mask = 3'b011; ALUresult = 64'h8000_0080;
        pc = 64'h8000_2000; inst = 32'hABCD_0001; reg_wr_addr = 5'd9; dreq_ready = 1;
        @(negedge clk);
        chk("rstw.valid", dreq_valid, 1);
        @(posedge clk); #1;
        dreq_ready = 0;
        @(negedge clk);
        chk("rstw.stall", stall, 1);
        @(posedge clk); #1;
        set_nop();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        drsp_valid = 1; drsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        chk("rstw.wb_rw", wb_RegWrite, 0);
        chk("rstw.wb_addr", wb_reg_wr_addr, 0);
        chk("rstw.wb_data", wb_reg_wr_data, 0);
        chk("rstw.wb_pc", wb_pc, 0);
        chk("rstw.wb_inst", wb_inst, 0);
        @(negedge clk);
        chk("rstw.valid_idle", dreq_valid, 0);
        chk("rstw.stall_idle", stall, 0);
        @(posedge clk); #1;
        drsp_valid = 0;
        chk("rstw.stale_data", wb_reg_wr_data, 0);
        mem_op("rstw_ld", 1, 3'b010, 64'h8000_0084, 0, 64'h0000_0001_7FFF_FFFF, 1, 1,
               64'h0000_0000_0000_0001, 0, 0);

        // Randomized mix of loads, stores and non-memory instructions
        for (int n = 0; n < 60; n++) begin
            int          kind = $urandom_range(0, 2);
            logic [2:0]  mask;
            logic [63:0] alu = {$urandom, $urandom};
            logic [63:0] wd  = {$urandom, $urandom};
            logic [63:0] rd  = {$urandom, $urandom};
            if (kind == 0) begin
                nop_op("rnd_nop", 1'($urandom_range(0, 1)) & ($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 1)) & ($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), alu, wd);
            end else if (kind == 1) begin
                mask = 3'($urandom_range(0, 6));
                mem_op("rnd_ld", 1, mask, alu, 0, rd, $urandom_range(0, 2), $urandom_range(0, 2),
                       ref_load(mask, alu[2:0], rd), 0, 0);
            end else begin
                mask = 3'($urandom_range(0, 3));
                mem_op("rnd_st", 0, mask, alu, wd, rd, $urandom_range(0, 2), $urandom_range(0, 2),
                       0, ref_strb(mask, alu[2:0]), ref_wdata(alu[2:0], wd));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
